// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard sequencer: forwarding, load-use, memory-wait freeze, perf counters
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic             MemRead_E,
    input  logic             BranchTaken_E,
    input  logic [4:0]       Rd_M,
    input  logic             RegWrite_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_W,
    input  logic             MemReq_M,
    input  logic             MemReady,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mw;
    logic lu;
    logic branch_flush;

    // MEM beats WB so the youngest producer wins; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
        if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
        ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
        lu = MemRead_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        mw            = 1'b0;
        unique case (state_q)
            RUN: begin
                mw = MemReq_M && !MemReady;
                if (mw) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                mw = !MemReady;
                if (MemReady) begin
                    state_d = RUN;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // The timeout only flags a slow memory; the wait itself continues.
        if (mw && (wait_cnt_d == WAIT_MAX)) mem_timeout_d = 1'b1;
    end

    always_comb begin
        Stall_F      = 1'b0;
        Stall_D      = 1'b0;
        Stall_E      = 1'b0;
        Stall_M      = 1'b0;
        Flush_D      = 1'b0;
        Flush_E      = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (mw) begin
            // Freeze holds any pending branch in E; it redirects after release.
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
        end else if (BranchTaken_E) begin
            Flush_D      = 1'b1;
            Flush_E      = 1'b1;
            branch_flush = 1'b1;
        end else if (lu) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_F && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 6;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic             MemRead_E, BranchTaken_E, RegWrite_M, RegWrite_W, MemReq_M, MemReady;
    logic             Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E;
    logic [1:0]       ForwardA_E, ForwardB_E;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .MemRead_E(MemRead_E), .BranchTaken_E(BranchTaken_E),
        .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
        .MemReq_M(MemReq_M), .MemReady(MemReady),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: was the previous cycle a memory wait, and how long has it lasted.
    bit m_waiting = 1'b0;
    int m_wlen    = 0;
    bit m_tmo     = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rst = 1'b0;
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
        {MemRead_E, BranchTaken_E, RegWrite_M, RegWrite_W, MemReq_M, MemReady} = '0;
    endtask

    // Checks one cycle against the model (inputs already applied), then advances it.
    task automatic cycle();
        bit mw, lu, br;
        logic [5:0] ctrl;
        #1;
        mw = m_waiting ? !MemReady : (MemReq_M && !MemReady);
        lu = MemRead_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
        br = 1'b0;
        ctrl = 6'b000000; // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}
        if (rst)                ctrl = 6'b000011;
        else if (mw)            ctrl = 6'b111100;
        else if (BranchTaken_E) begin ctrl = 6'b000011; br = 1'b1; end
        else if (lu)            ctrl = 6'b110001;
        check("ctrl", {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E}, ctrl);
        check("fwd_a", ForwardA_E, ref_fwd(Rs1_E));
        check("fwd_b", ForwardB_E, ref_fwd(Rs2_E));
        check("mem_timeout", mem_timeout, m_tmo);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(posedge clk);
        if (rst) begin
            m_waiting = 1'b0; m_wlen = 0; m_tmo = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (mw) begin
                m_wlen    = m_waiting ? ((m_wlen < MAX_WAIT) ? m_wlen + 1 : MAX_WAIT) : 1;
                m_waiting = 1'b1;
                if (m_wlen == MAX_WAIT) m_tmo = 1'b1;
            end else begin
                m_waiting = 1'b0;
            end
            if (ctrl[5] && m_stall < CMAX) m_stall++;
            if (br && m_flush < CMAX) m_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        #1;
        check("rst_ctrl", {Flush_D, Flush_E, Stall_F, Stall_D}, 4'b1100);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_timeout", mem_timeout, 0);
        cycle();

        // Load-use: one bubble
        idle(); MemRead_E = 1; Rd_E = 5; Rs1_D = 5;
        #1;
        check("lu_ctrl", {Stall_F, Stall_D, Stall_E, Flush_E, Flush_D}, 5'b11010);
        cycle();
        check("lu_stall_cnt", stall_cnt, 1);
        MemRead_E = 0;
        cycle();
        check("lu_bubble_stall_cnt", stall_cnt, 1);

        // Forwarding
        idle(); Rd_M = 7; Rd_W = 7; RegWrite_M = 1; RegWrite_W = 1; Rs1_E = 7; Rs2_E = 7;
        #1;
        check("fwd_mem_wins", ForwardA_E, 2'b10);
        RegWrite_M = 0;
        #1;
        check("fwd_wb", ForwardB_E, 2'b01);
        Rd_M = 0; Rd_W = 0; RegWrite_M = 1; Rs1_E = 0; Rs2_E = 0;
        #1;
        check("fwd_x0", {ForwardA_E, ForwardB_E}, 4'b0000);
        cycle();

        // Branch beats load-use
        idle(); BranchTaken_E = 1; MemRead_E = 1; Rd_E = 5; Rs2_D = 5;
        #1;
        check("br_ctrl", {Flush_D, Flush_E, Stall_F, Stall_D}, 4'b1100);
        cycle();
        check("br_flush_cnt", flush_cnt, 1);

        // Three-cycle memory wait, Mealy release
        idle(); MemReq_M = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_stalls", {Stall_F, Stall_D, Stall_E, Stall_M}, 4'hF);
            cycle();
        end
        MemReady = 1;
        #1;
        check("mw_release", {Stall_F, Stall_D, Stall_E, Stall_M}, 4'h0);
        cycle();
        MemReq_M = 0; MemReady = 0;
        cycle();
        check("mw_stall_cnt", stall_cnt, 4);

        // Timeout after MAX_WAIT low cycles, sticky until reset
        idle(); MemReq_M = 1;
        repeat (MAX_WAIT - 1) cycle();
        check("tmo_not_yet", mem_timeout, 0);
        cycle();
        check("tmo_set", mem_timeout, 1);
        MemReady = 1;
        cycle();
        idle();
        repeat (3) cycle();
        check("tmo_sticky", mem_timeout, 1);

        // Reset during a wait
        idle(); MemReq_M = 1;
        cycle();
        rst = 1;
        #1;
        check("rst_in_wait_ctrl", {Flush_D, Flush_E, Stall_F, Stall_M}, 4'b1100);
        cycle();
        check("rst_in_wait_cnts", {stall_cnt, flush_cnt, mem_timeout}, 0);
        idle();
        #1;
        check("rst_in_wait_run", Stall_F, 0);
        cycle();

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            Rs1_D         = 5'($urandom_range(0, 3));
            Rs2_D         = 5'($urandom_range(0, 3));
            Rs1_E         = 5'($urandom_range(0, 3));
            Rs2_E         = 5'($urandom_range(0, 3));
            Rd_E          = 5'($urandom_range(0, 3));
            Rd_M          = 5'($urandom_range(0, 3));
            Rd_W          = 5'($urandom_range(0, 3));
            MemRead_E     = 1'($urandom_range(0, 1));
            BranchTaken_E = ($urandom_range(0, 7) == 0);
            RegWrite_M    = 1'($urandom_range(0, 1));
            RegWrite_W    = 1'($urandom_range(0, 1));
            MemReq_M      = ($urandom_range(0, 3) == 0);
            MemReady      = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
